// File: rtl/ir_cash_fill.sv
// Instruction cash: fills from external memory after reset or refill, then serves decoder reads.
// Optional macro IR_CASH_PARITY_EN adds per-entry even parity and o_parity_err.
module ir_cash_fill #(
    parameter int DATA_WIDTH    = 16,
    parameter int IR_ADDR_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     o_ext_req,
    output logic [IR_ADDR_WIDTH-1:0] o_ext_addr,
    input  logic                     i_ext_ack,
    input  logic [DATA_WIDTH-1:0]    i_ext_data,
    input  logic                     i_refill,
    output logic                     o_cash_init_done,
    input  logic [IR_ADDR_WIDTH-1:0] i_irp,
    input  logic                     i_ren,
    output logic [DATA_WIDTH-1:0]    o_data,
`ifdef IR_CASH_PARITY_EN
    output logic                     o_parity_err,
`endif
    output logic                     o_data_valid
);

    localparam int DEPTH = 2 ** IR_ADDR_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [IR_ADDR_WIDTH-1:0] r_cnt;
    logic                     r_done;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

    logic w_fill;
    logic w_serve;
    logic w_last;
    logic w_wr;
    logic w_rd;

    assign w_fill  = (r_state == FILL);
    assign w_serve = (r_state == SERVE);
    assign w_last  = &r_cnt;
    assign w_wr    = rst_n && w_fill && i_ext_ack;
    assign w_rd    = w_serve && i_ren;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FILL;
            FILL:    if (i_ext_ack && w_last) w_state_nxt = SERVE;
            SERVE:   if (i_refill) w_state_nxt = FILL;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == SERVE);
            r_valid <= w_rd;
            // Counter wraps to 0 on the final ack, so SERVE always starts at 0.
            if (w_fill && i_ext_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_serve && i_refill) begin
                r_cnt <= '0;
            end
            if (w_rd) begin
                r_data <= r_mem[i_irp];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_cnt] <= i_ext_data;
        end
    end

`ifdef IR_CASH_PARITY_EN
    logic r_par [DEPTH];
    logic r_perr;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_par[r_cnt] <= ^i_ext_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_rd && ((^r_mem[i_irp]) != r_par[i_irp]);
        end
    end

    assign o_parity_err = r_perr;
`endif

    assign o_ext_req        = w_fill;
    assign o_ext_addr       = r_cnt;
    assign o_cash_init_done = r_done;
    assign o_data           = r_data;
    assign o_data_valid     = r_valid;

endmodule
